// File: rtl/dma_mem_access_pkg.sv
// Shared types and constants for the memory-side DMA engine.
package dma_pkg;
  localparam int ADDR_W_DEF = 21;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Strobe counter preload; the counter runs down to zero inclusive.
  function automatic logic [CNT_W-1:0] wait_load(input logic rnw,
                                                 input int   rd_wait,
                                                 input int   wr_wait);
    return rnw ? CNT_W'(rd_wait - 1) : CNT_W'(wr_wait - 1);
  endfunction
endpackage

// File: rtl/dma_mem_access_if.sv
// Single-beat request/ack/end handshake between the DMA controller and the memory engine.
interface dma_mem_access_if
  import dma_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              dma_req;
  logic [ADDR_W-1:0] dma_addr;
  logic [7:0]        dma_wd;
  logic              dma_rnw;
  logic              dma_ack;
  logic              dma_end;
  logic [7:0]        dma_rd;

  modport master (output dma_req, dma_addr, dma_wd, dma_rnw,
                  input  dma_ack, dma_end, dma_rd);
  modport slave  (input  dma_req, dma_addr, dma_wd, dma_rnw,
                  output dma_ack, dma_end, dma_rd);
endinterface

// File: rtl/dma_mem_access.sv
// One SRAM read or write per DMA request, borrowing the memory bus only while the Z80 is idle.
module dma_mem_access
  import dma_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  dma_mem_access_if.slave   dma,
  input  logic              cpu_req,
  output logic              dma_bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_dout,
  output logic              mem_dout_en,
  input  logic [7:0]        mem_din,
  output logic              mem_rd_n,
  output logic              mem_we_n
);
  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              rnw_q;
  logic              ack_q, end_q, bus_q, dout_en_q, rd_n_q, we_n_q;
  logic [7:0]        rd_q, dout_q;
  logic [ADDR_W-1:0] addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rnw_q     <= 1'b0;
      ack_q     <= 1'b0;
      end_q     <= 1'b0;
      bus_q     <= 1'b0;
      dout_en_q <= 1'b0;
      rd_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      rd_q      <= 8'h00;
      dout_q    <= 8'h00;
      addr_q    <= '0;
    end else begin
      ack_q <= 1'b0;
      end_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Z80 owns the bus whenever it asks; the request simply waits.
          if (dma.dma_req && !cpu_req) begin
            addr_q    <= dma.dma_addr;
            dout_q    <= dma.dma_wd;
            rnw_q     <= dma.dma_rnw;
            ack_q     <= 1'b1;
            bus_q     <= 1'b1;
            dout_en_q <= !dma.dma_rnw;
            state_q   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          rd_n_q  <= !rnw_q;
          we_n_q  <= rnw_q;
          cnt_q   <= wait_load(rnw_q, RD_WAIT, WR_WAIT);
          state_q <= ST_STROBE;
        end
        ST_STROBE: begin
          if (cnt_q == '0) begin
            rd_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            if (rnw_q) rd_q <= mem_din;
            end_q   <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DONE: begin
          // Address and data stay put through this cycle for write hold time.
          bus_q     <= 1'b0;
          dout_en_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dma.dma_ack = ack_q;
  assign dma.dma_end = end_q;
  assign dma.dma_rd  = rd_q;
  assign dma_bus     = bus_q;
  assign mem_addr    = addr_q;
  assign mem_dout    = dout_q;
  assign mem_dout_en = dout_en_q;
  assign mem_rd_n    = rd_n_q;
  assign mem_we_n    = we_n_q;
endmodule
